// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, default baud divisor and
// frame geometry, also used by the matching transmitter.
package uart_pkg;

    localparam int UART_BAUD_DIV = 2604;

    // Eight data bits plus one stop bit are shifted in after the start bit.
    localparam int UART_FRAME_BITS = 9;

    localparam logic UART_IDLE_LEVEL = 1'b1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        START   = 2'd1,
        RECEIVE = 2'd2
    } rx_state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// Brings the asynchronous RX pin into the clk domain through two flops and
// adds a third flop so a falling edge of the synchronized line can be detected.
module uart_rx_sync
    import uart_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic rx_in,
    output logic rx_s,
    output logic rx_fall
);

    logic meta_q;
    logic meta_d;
    logic sync_q;
    logic sync_d;
    logic prev_q;
    logic prev_d;

    always_comb begin
        meta_d = rx_in;
        sync_d = meta_q;
        prev_d = sync_q;
    end

    // Resetting to the idle level keeps a reset from looking like a start edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= UART_IDLE_LEVEL;
            sync_q <= UART_IDLE_LEVEL;
            prev_q <= UART_IDLE_LEVEL;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign rx_s    = sync_q;
    assign rx_fall = prev_q & ~sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: validates the start bit at mid-period, samples each bit
// at its centre and presents the byte with ready and framing-error flags.
module uart_rx
    import uart_pkg::*;
#(
    parameter int BAUD_DIV = UART_BAUD_DIV
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       RX,
    input  logic       clr_rdy,
    output logic [7:0] rx_data,
    output logic       rdy,
    output logic       frm_err
);

    localparam int CW = $clog2(BAUD_DIV);
    localparam logic [CW-1:0] HALF_LOAD = CW'(BAUD_DIV / 2);
    localparam logic [CW-1:0] FULL_LOAD = CW'(BAUD_DIV - 1);
    localparam logic [3:0]    LAST_BIT  = 4'(UART_FRAME_BITS - 1);

    logic rx_s;
    logic rx_fall;

    rx_state_t       state_q;
    rx_state_t       state_d;
    logic [CW-1:0]   baud_cnt_q;
    logic [CW-1:0]   baud_cnt_d;
    logic [3:0]      bit_cnt_q;
    logic [3:0]      bit_cnt_d;
    logic [8:0]      shift_q;
    logic [8:0]      shift_d;
    logic [7:0]      rx_data_q;
    logic [7:0]      rx_data_d;
    logic            rdy_q;
    logic            rdy_d;
    logic            frm_err_q;
    logic            frm_err_d;
    logic            baud_tick;
    logic [8:0]      shift_next;

    uart_rx_sync u_sync (
        .clk     (clk),
        .rst     (rst),
        .rx_in   (RX),
        .rx_s    (rx_s),
        .rx_fall (rx_fall)
    );

    assign baud_tick  = (baud_cnt_q == '0);
    assign shift_next = {rx_s, shift_q[8:1]};

    always_comb begin
        state_d    = state_q;
        baud_cnt_d = baud_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        rx_data_d  = rx_data_q;
        rdy_d      = rdy_q;
        frm_err_d  = frm_err_q;

        // Acknowledge first so a completing frame below overrides it.
        if (clr_rdy) begin
            rdy_d     = 1'b0;
            frm_err_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (rx_fall) begin
                    baud_cnt_d = HALF_LOAD;
                    bit_cnt_d  = 4'd0;
                    rdy_d      = 1'b0;
                    state_d    = START;
                end
            end

            START: begin
                if (baud_tick) begin
                    baud_cnt_d = FULL_LOAD;
                    state_d    = rx_s ? IDLE : RECEIVE;
                end else begin
                    baud_cnt_d = baud_cnt_q - 1'b1;
                end
            end

            RECEIVE: begin
                if (baud_tick) begin
                    baud_cnt_d = FULL_LOAD;
                    shift_d    = shift_next;
                    bit_cnt_d  = bit_cnt_q + 4'd1;
                    // Ninth sample is the stop bit; a bad stop still delivers the byte.
                    if (bit_cnt_q == LAST_BIT) begin
                        rx_data_d = shift_next[7:0];
                        frm_err_d = ~shift_next[8];
                        rdy_d     = 1'b1;
                        state_d   = IDLE;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q - 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            baud_cnt_q <= '0;
            bit_cnt_q  <= 4'd0;
            shift_q    <= 9'd0;
            rx_data_q  <= 8'h00;
            rdy_q      <= 1'b0;
            frm_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            rx_data_q  <= rx_data_d;
            rdy_q      <= rdy_d;
            frm_err_q  <= frm_err_d;
        end
    end

    assign rx_data = rx_data_q;
    assign rdy     = rdy_q;
    assign frm_err = frm_err_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed frames plus randomized traffic,
// compared every cycle against an event-scheduled model of the receiver outputs.
module tb_uart_rx;

    localparam int B        = 16;
    localparam int H        = B / 2;
    // Cycles from the pin's falling edge to the visible output update.
    localparam int DONE_OFS = 3 + H + 9 * B + 1;
    localparam int DROP_OFS = 3;

    localparam int EV_RST  = 0;
    localparam int EV_CLR  = 1;
    localparam int EV_DROP = 2;
    localparam int EV_DONE = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       RX = 1'b1;
    logic       clr_rdy = 1'b0;
    logic [7:0] rx_data;
    logic       rdy;
    logic       frm_err;

    uart_rx #(.BAUD_DIV(B)) dut (
        .clk     (clk),
        .rst     (rst),
        .RX      (RX),
        .clr_rdy (clr_rdy),
        .rx_data (rx_data),
        .rdy     (rdy),
        .frm_err (frm_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    typedef struct {
        int         at;
        int         kind;
        logic [7:0] data;
        logic       ferr;
    } ev_t;

    ev_t        evq[$];
    logic       m_rdy = 1'b0;
    logic       m_ferr = 1'b0;
    logic [7:0] m_data = 8'h00;
    bit         cmp_en = 1'b0;
    bit         rand_done = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Model: outputs change only at scheduled events; acknowledge is applied
    // before completion so a coinciding completion wins.
    initial begin
        forever begin
            @(negedge clk);
            if (cmp_en) begin
                for (int k = 0; k < 4; k++) begin
                    foreach (evq[i]) begin
                        if (evq[i].at == cyc && evq[i].kind == k) begin
                            case (k)
                                EV_RST:  begin m_rdy = 1'b0; m_ferr = 1'b0; m_data = 8'h00; end
                                EV_CLR:  begin m_rdy = 1'b0; m_ferr = 1'b0; end
                                EV_DROP: m_rdy = 1'b0;
                                default: begin m_rdy = 1'b1; m_ferr = evq[i].ferr; m_data = evq[i].data; end
                            endcase
                        end
                    end
                end
                for (int i = evq.size() - 1; i >= 0; i--) begin
                    if (evq[i].at <= cyc) evq.delete(i);
                end
                check("model_rdy", 32'(rdy), 32'(m_rdy));
                check("model_rx_data", 32'(rx_data), 32'(m_data));
                check("model_frm_err", 32'(frm_err), 32'(m_ferr));
            end
        end
    end

    task automatic send_frame(input logic [7:0] d, input logic stop);
        int k;
        k = cyc;
        evq.push_back(ev_t'{k + DROP_OFS, EV_DROP, 8'h00, 1'b0});
        evq.push_back(ev_t'{k + DONE_OFS, EV_DONE, d, ~stop});
        RX = 1'b0;
        step(B);
        for (int i = 0; i < 8; i++) begin
            RX = d[i];
            step(B);
        end
        RX = stop;
        step(B);
        RX = 1'b1;
        $display("frame data=%02h stop=%0b start_cyc=%0d", d, stop, k);
    endtask

    task automatic clr_pulse();
        clr_rdy = 1'b1;
        evq.push_back(ev_t'{cyc + 1, EV_CLR, 8'h00, 1'b0});
        step(1);
        clr_rdy = 1'b0;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        RX  = 1'b1;
        evq.delete();
        evq.push_back(ev_t'{cyc + 1, EV_RST, 8'h00, 1'b0});
        step(n);
        rst = 1'b0;
        $display("reset asserted for %0d cycles at cyc=%0d", n, cyc);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int         k;
        int         got;
        int         gap;
        logic [7:0] d;
        logic       stop;
        logic       prev_stop;

        step(2);
        cmp_en = 1'b1;
        check("reset_rdy", 32'(rdy), 32'd0);
        check("reset_rx_data", 32'(rx_data), 32'h00);
        check("reset_frm_err", 32'(frm_err), 32'd0);
        rst = 1'b0;
        step(2);

        // Frame 0xA5: latency window and content.
        k   = cyc;
        got = -1;
        fork
            send_frame(8'hA5, 1'b1);
            begin
                for (int i = 0; i < DONE_OFS + 20; i++) begin
                    @(negedge clk);
                    if (rdy === 1'b1) begin
                        got = cyc;
                        break;
                    end
                end
            end
        join
        check("a5_latency", 32'(got >= k + DONE_OFS - 1 && got <= k + DONE_OFS + 1), 32'd1);
        check("a5_data", 32'(rx_data), 32'hA5);
        check("a5_frm_err", 32'(frm_err), 32'd0);
        clr_pulse();
        check("a5_clr_rdy", 32'(rdy), 32'd0);
        step(3);

        // Back-to-back 0x00 then 0xFF.
        send_frame(8'h00, 1'b1);
        check("b2b_first_data", 32'(rx_data), 32'h00);
        check("b2b_first_rdy", 32'(rdy), 32'd1);
        k = cyc;
        fork
            send_frame(8'hFF, 1'b1);
            begin
                repeat (3) @(negedge clk);
                check("b2b_before_drop", 32'(rdy), 32'd1);
                @(negedge clk);
                check("b2b_drop_at_start", 32'(rdy), 32'd0);
            end
        join
        check("b2b_second_data", 32'(rx_data), 32'hFF);
        check("b2b_second_rdy", 32'(rdy), 32'd1);
        step(3);

        // Framing error frame 0x3C.
        send_frame(8'h3C, 1'b0);
        check("ferr_data", 32'(rx_data), 32'h3C);
        check("ferr_rdy", 32'(rdy), 32'd1);
        check("ferr_flag", 32'(frm_err), 32'd1);
        clr_pulse();
        check("ferr_clr_rdy", 32'(rdy), 32'd0);
        check("ferr_clr_flag", 32'(frm_err), 32'd0);
        step(B);

        // Short glitch on idle line.
        evq.push_back(ev_t'{cyc + DROP_OFS, EV_DROP, 8'h00, 1'b0});
        RX = 1'b0;
        step(4);
        RX = 1'b1;
        step(2 * B);
        $display("glitch of 4 cycles done at cyc=%0d", cyc);
        check("glitch_rdy", 32'(rdy), 32'd0);
        check("glitch_rx_data", 32'(rx_data), 32'h3C);

        // clr_rdy on the completion cycle of 0x7E.
        k = cyc;
        fork
            send_frame(8'h7E, 1'b1);
            begin
                while (cyc < k + DONE_OFS - 1) step(1);
                clr_pulse();
            end
        join
        check("setwins_rdy", 32'(rdy), 32'd1);
        check("setwins_data", 32'(rx_data), 32'h7E);
        step(2);

        // Reset in the middle of data bit 4 of 0x5A.
        d = 8'h5A;
        evq.push_back(ev_t'{cyc + DROP_OFS, EV_DROP, 8'h00, 1'b0});
        RX = 1'b0;
        step(B);
        for (int i = 0; i < 4; i++) begin
            RX = d[i];
            step(B);
        end
        RX = d[4];
        step(H);
        do_reset(2);
        check("midreset_rdy", 32'(rdy), 32'd0);
        check("midreset_rx_data", 32'(rx_data), 32'h00);
        check("midreset_frm_err", 32'(frm_err), 32'd0);
        step(B);
        send_frame(8'h81, 1'b1);
        check("after_reset_data", 32'(rx_data), 32'h81);
        check("after_reset_rdy", 32'(rdy), 32'd1);
        check("after_reset_frm_err", 32'(frm_err), 32'd0);

        // Randomized traffic with asynchronous acknowledges.
        prev_stop = 1'b1;
        fork
            begin
                for (int n = 0; n < 30; n++) begin
                    d    = 8'($urandom);
                    stop = ($urandom_range(3) != 0);
                    gap  = prev_stop ? int'($urandom_range(2 * B)) : B + int'($urandom_range(B));
                    step(gap);
                    send_frame(d, stop);
                    prev_stop = stop;
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    step(int'($urandom_range(200, 20)));
                    if (!rand_done) clr_pulse();
                end
            end
        join
        step(2 * B);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
